pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-side program-counter sequencer feeding the IF/ID pipeline register. It loads the start PC from a two-word reset vector in instruction memory, then steps the PC by one each cycle and presents the addressed instruction word. It applies redirects from jump/return resolution, holds on stall, and inserts bubbles when the flush controller asserts `flush`. It sits directly upstream of decode and consumes the flush controller's `flush` output.

## Interface
- `PC_W`, 32, program counter width; must be at least 17.
- `INSTR_W`, 16, instruction and memory word width.
- `RESET_VEC_ADDR`, 0, memory address of the low vector word. The high word is at `RESET_VEC_ADDR+1`.
- `RESET_PC`, 0, start PC when `PC_SEQ_RESET_VECTOR_EN` is undefined.
- `NOP`, 0, instruction value inserted as a bubble.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `stall` in 1: hazard unit hold request.
- `flush` in 1: from the flush controller; kills the word being fetched.
- `jump_taken` in 1: redirect to `jump_target`.
- `jump_target` in PC_W: jump destination.
- `ret_valid` in 1: redirect to `ret_pc`; used for return/RTI popped from the stack.
- `ret_pc` in PC_W: return destination.
- `imem_data` in INSTR_W: asynchronous-read instruction memory data.
- `imem_addr` out PC_W: instruction memory address (combinational).
- `ifid_instr` out INSTR_W: registered instruction to decode.
- `ifid_pc` out PC_W: registered PC of `ifid_instr`.
- `ifid_valid` out 1: `ifid_instr` is a real instruction, not a bubble.
- `fetch_busy` out 1: high while the reset vector is being loaded.

## Operation
- Registered state: `pc`, `ifid_instr`, `ifid_pc`, `ifid_valid`, and the 2-bit FSM `state` ∈ {VEC_LO, VEC_HI, RUN}.
- Reset (`rst`=0, asynchronous) sets all of the following:
  - `pc`=0, `ifid_instr`=`NOP`, `ifid_pc`=0, `ifid_valid`=0.
  - `state`=VEC_LO.
- VEC_LO:
  - `imem_addr`=`RESET_VEC_ADDR`, `fetch_busy`=1.
  - On the next edge: `pc[INSTR_W-1:0]`<=`imem_data`, then go to VEC_HI.
- VEC_HI:
  - `imem_addr`=`RESET_VEC_ADDR+1`, `fetch_busy`=1.
  - On the next edge: `pc[PC_W-1:INSTR_W]`<=`imem_data` zero-extended or truncated to fit, then go to RUN.
- In VEC_LO and VEC_HI, `stall`, `flush`, `jump_taken` and `ret_valid` are ignored, and the IF/ID outputs hold their reset values.
- RUN: `imem_addr`=`pc`, `fetch_busy`=0. PC update, highest priority first:
  1. `ret_valid`: `pc`<=`ret_pc`.
  2. `jump_taken`: `pc`<=`jump_target`.
  3. `stall`: `pc` holds.
  4. Otherwise: `pc`<=`pc+1`, modulo 2^PC_W (all-ones wraps to 0).
- Redirects override `stall`. If `ret_valid` and `jump_taken` are asserted together, `ret_pc` wins.
- IF/ID update in RUN, highest priority first:
  1. `flush`: `ifid_instr`<=`NOP`, `ifid_valid`<=0, `ifid_pc`<=`pc`.
  2. `stall`: all IF/ID registers hold.
  3. Otherwise: `ifid_instr`<=`imem_data`, `ifid_pc`<=`pc`, `ifid_valid`<=1.
- A redirect without `flush` still latches the current word as valid. Squashing it is the flush controller's job.

## Timing
- Vector load takes 2 cycles after reset release. The first RUN fetch happens on cycle 3, and the first `ifid_valid`=1 appears after the 3rd rising edge.
- Fetch latency is 1 cycle: word at address `pc` appears on `ifid_instr` after the next edge.
- Redirect latency is 1 cycle: `imem_addr` equals the target in the cycle after `jump_taken`/`ret_valid` is sampled.
- Flush takes effect at the same edge it is sampled. Consecutive `flush` cycles produce consecutive bubbles; the flush controller holds `flush` up to 3 cycles.
- Asserting `rst` mid-RUN clears outputs immediately and restarts the vector load after release.

## Configuration
- `PC_SEQ_RESET_VECTOR_EN` defined:
  - Behaviour as described above.
- `PC_SEQ_RESET_VECTOR_EN` undefined:
  - VEC_LO and VEC_HI are removed; reset puts `state`=RUN and `pc`=`RESET_PC`.
  - `fetch_busy` is tied to 0.
  - The first fetch occurs in the first cycle after reset release.

## Test plan
- Vector load: mem[0]=0x0010, mem[1]=0x0000, release `rst` → `fetch_busy`=1 for 2 cycles, then `imem_addr`=0x10, and next cycle `ifid_pc`=0x10 with `ifid_valid`=1.
- Sequential fetch with stall: from `pc`=0x10, assert `stall` for cycle 2 of 4 → `ifid_pc` sequence 0x10, 0x10, 0x11, 0x12.
- Jump plus flush: `jump_taken`=1, `jump_target`=0x200, `flush`=1 for 1 cycle → that cycle's IF/ID is `NOP` with valid=0, and the next `ifid_pc`=0x200.
- Simultaneous redirects: `ret_valid`=1 (`ret_pc`=0x40) with `jump_taken`=1 (0x80) and `stall`=1 → `imem_addr`=0x40 next cycle.
- Flush over stall, and wrap-around:
  - `stall`=1 with `flush`=1 → `ifid_valid`=0, and `pc` holds.
  - `pc`=0xFFFFFFFF → next `pc`=0.
- Mid-run reset: assert `rst`=0 between edges → `ifid_valid`=0 and `imem_addr`=`RESET_VEC_ADDR` without waiting for a clock edge. With the macro undefined, `pc`=`RESET_PC`.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// ----------------------------------------------------------------------------
// pc_sequencer_if
//   Groups the fetch-side control inputs, the instruction-memory port and the
//   IF/ID pipeline-register outputs of pc_sequencer into one bundle.
//
//   master : the sequencer side (consumes control + imem_data, drives the
//            memory address, the IF/ID outputs and fetch_busy).
//   slave  : the surrounding pipeline / memory side.
//
//   Signals:
//     stall, flush, jump_taken, ret_valid  - control requests into fetch
//     jump_target, ret_pc                  - redirect destinations
//     imem_data                            - async-read instruction word
//     imem_addr                            - instruction memory address
//     ifid_instr, ifid_pc, ifid_valid      - IF/ID register contents
//     fetch_busy                           - reset vector load in progress
// ----------------------------------------------------------------------------
interface pc_sequencer_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 16
) ();
  logic               stall;
  logic               flush;
  logic               jump_taken;
  logic [PC_W-1:0]    jump_target;
  logic               ret_valid;
  logic [PC_W-1:0]    ret_pc;
  logic [INSTR_W-1:0] imem_data;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] ifid_instr;
  logic [PC_W-1:0]    ifid_pc;
  logic               ifid_valid;
  logic               fetch_busy;

  modport master (
    input  stall, flush, jump_taken, jump_target, ret_valid, ret_pc, imem_data,
    output imem_addr, ifid_instr, ifid_pc, ifid_valid, fetch_busy
  );

  modport slave (
    output stall, flush, jump_taken, jump_target, ret_valid, ret_pc, imem_data,
    input  imem_addr, ifid_instr, ifid_pc, ifid_valid, fetch_busy
  );
endinterface

// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
//   Fetch-side program-counter sequencer feeding the IF/ID register. Steps the
//   PC by one per cycle, applies return/jump redirects, holds on stall and
//   inserts NOP bubbles on flush.
//
//   Optional feature (macro PC_SEQ_RESET_VECTOR_EN):
//     defined   - after reset the start PC is read from a two-word vector in
//                 instruction memory (low word at RESET_VEC_ADDR, high word at
//                 RESET_VEC_ADDR+1); fetch_busy is high during the load.
//     undefined - reset starts fetching directly at RESET_PC; fetch_busy = 0.
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-low reset
//     bus  - pc_sequencer_if.master (control inputs, imem port, IF/ID outputs)
// ----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int                 PC_W           = 32,
  parameter int                 INSTR_W        = 16,
`ifdef PC_SEQ_RESET_VECTOR_EN
  parameter logic [PC_W-1:0]    RESET_VEC_ADDR = '0,
`else
  parameter logic [PC_W-1:0]    RESET_PC       = '0,
`endif
  parameter logic [INSTR_W-1:0] NOP            = '0
) (
  input logic            clk,
  input logic            rst,
  pc_sequencer_if.master bus
);

  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_nxt;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic [PC_W-1:0]    r_ifid_pc;
  logic               r_ifid_valid;
  logic               w_run;
  logic               w_fetch_busy;
  logic [PC_W-1:0]    w_imem_addr;

`ifdef PC_SEQ_RESET_VECTOR_EN
  localparam int              HI_W   = PC_W - INSTR_W;
  localparam logic [PC_W-1:0] PC_RST = '0;

  typedef enum logic [1:0] {
    VEC_LO = 2'd0,
    VEC_HI = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_ld_lo;
  logic            w_ld_hi;
  logic [HI_W-1:0] w_vec_hi;

  // High vector word is zero-extended or truncated into the upper PC bits.
  assign w_vec_hi = HI_W'(bus.imem_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= VEC_LO;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      VEC_LO:  w_state_nxt = VEC_HI;
      VEC_HI:  w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = VEC_LO;
    endcase
  end

  // Memory address is combinational so a mid-run reset immediately points it
  // back at the vector.
  always_comb begin
    w_run        = 1'b0;
    w_ld_lo      = 1'b0;
    w_ld_hi      = 1'b0;
    w_fetch_busy = 1'b1;
    w_imem_addr  = r_pc;
    case (r_state)
      VEC_LO: begin
        w_ld_lo     = 1'b1;
        w_imem_addr = RESET_VEC_ADDR;
      end
      VEC_HI: begin
        w_ld_hi     = 1'b1;
        w_imem_addr = RESET_VEC_ADDR + PC_W'(1);
      end
      RUN: begin
        w_run        = 1'b1;
        w_fetch_busy = 1'b0;
      end
      default: ;
    endcase
  end
`else
  localparam logic [PC_W-1:0] PC_RST = RESET_PC;

  assign w_run        = 1'b1;
  assign w_fetch_busy = 1'b0;
  assign w_imem_addr  = r_pc;
`endif

  // Redirects outrank stall; return outranks jump.
  always_comb begin
    w_pc_nxt = r_pc;
    if (w_run) begin
      if (bus.ret_valid)       w_pc_nxt = bus.ret_pc;
      else if (bus.jump_taken) w_pc_nxt = bus.jump_target;
      else if (!bus.stall)     w_pc_nxt = r_pc + PC_W'(1);
    end
`ifdef PC_SEQ_RESET_VECTOR_EN
    else if (w_ld_lo) w_pc_nxt[INSTR_W-1:0]    = bus.imem_data;
    else if (w_ld_hi) w_pc_nxt[PC_W-1:INSTR_W] = w_vec_hi;
`endif
  end

  // ---- PC register -> instruction memory address ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pc <= PC_RST;
    else      r_pc <= w_pc_nxt;
  end

  // ---- IF/ID register: flush beats stall, redirects do not squash ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ifid_instr <= NOP;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
    end else if (w_run) begin
      if (bus.flush) begin
        r_ifid_instr <= NOP;
        r_ifid_pc    <= r_pc;
        r_ifid_valid <= 1'b0;
      end else if (!bus.stall) begin
        r_ifid_instr <= bus.imem_data;
        r_ifid_pc    <= r_pc;
        r_ifid_valid <= 1'b1;
      end
    end
  end

  assign bus.imem_addr  = w_imem_addr;
  assign bus.fetch_busy = w_fetch_busy;
  assign bus.ifid_instr = r_ifid_instr;
  assign bus.ifid_pc    = r_ifid_pc;
  assign bus.ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer with default parameters. Works with
//   PC_SEQ_RESET_VECTOR_EN either defined or undefined. Instruction memory is a
//   combinational function of the address: words 0/1 hold the reset vector
//   (0x0010, 0x0000), every other word is addr[15:0] ^ 0x5A5A.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam logic [15:0] NOP_W = 16'h0000;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  pc_sequencer_if #(.PC_W(32), .INSTR_W(16)) bus ();

  pc_sequencer dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    if (a == 32'd0)      return 16'h0010;
    else if (a == 32'd1) return 16'h0000;
    else                 return a[15:0] ^ 16'h5A5A;
  endfunction

  always_comb bus.imem_data = mem_word(bus.imem_addr);

  typedef struct {
    bit          rv;
    bit          jt;
    bit          st;
    bit          fl;
    logic [31:0] rpc;
    logic [31:0] jtgt;
    logic [31:0] e_addr;
    logic [31:0] e_ipc;
    bit          e_v;
  } vec_t;

  function automatic vec_t mk(bit rv, bit jt, bit st, bit fl,
                              logic [31:0] rpc, logic [31:0] jtgt,
                              logic [31:0] e_addr, logic [31:0] e_ipc, bit e_v);
    vec_t v;
    v.rv = rv; v.jt = jt; v.st = st; v.fl = fl;
    v.rpc = rpc; v.jtgt = jtgt;
    v.e_addr = e_addr; v.e_ipc = e_ipc; v.e_v = e_v;
    return v;
  endfunction

  vec_t tbl[18];
  vec_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.jump_taken  = 1'b0;
    bus.jump_target = '0;
    bus.ret_valid   = 1'b0;
    bus.ret_pc      = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, want finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t e;
    n_vec = 0;
    n_err = 0;

    // Table assumes pc = 0x10 at entry.
    tbl[0]  = mk(0,0,0,0, 0, 0,                32'h11,       32'h10,       1);
    tbl[1]  = mk(0,0,1,0, 0, 0,                32'h11,       32'h10,       1);
    tbl[2]  = mk(0,0,0,0, 0, 0,                32'h12,       32'h11,       1);
    tbl[3]  = mk(0,0,0,0, 0, 0,                32'h13,       32'h12,       1);
    tbl[4]  = mk(0,1,0,1, 0, 32'h200,          32'h200,      32'h13,       0);
    tbl[5]  = mk(0,0,0,0, 0, 0,                32'h201,      32'h200,      1);
    tbl[6]  = mk(1,1,1,0, 32'h40, 32'h80,      32'h40,       32'h200,      1);
    tbl[7]  = mk(0,0,0,0, 0, 0,                32'h41,       32'h40,       1);
    tbl[8]  = mk(0,0,1,1, 0, 0,                32'h41,       32'h41,       0);
    tbl[9]  = mk(0,0,0,1, 0, 0,                32'h42,       32'h41,       0);
    tbl[10] = mk(0,0,0,1, 0, 0,                32'h43,       32'h42,       0);
    tbl[11] = mk(0,1,0,0, 0, 32'hFFFF_FFFF,    32'hFFFF_FFFF, 32'h43,      1);
    tbl[12] = mk(0,0,0,0, 0, 0,                32'h0,        32'hFFFF_FFFF, 1);
    tbl[13] = mk(0,0,0,0, 0, 0,                32'h1,        32'h0,        1);
    tbl[14] = mk(1,0,0,0, 32'h1234, 0,         32'h1234,     32'h1,        1);
    tbl[15] = mk(0,0,1,0, 0, 0,                32'h1234,     32'h1,        1);
    tbl[16] = mk(0,1,1,0, 0, 32'h300,          32'h300,      32'h1,        1);
    tbl[17] = mk(0,0,0,0, 0, 0,                32'h301,      32'h300,      1);

    idle_inputs();
    rst_n = 1'b0;
    #12;

    // Reset state (reset still asserted)
    chk("rst ifid_valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("rst ifid_pc",    bus.ifid_pc,             32'd0);
    chk("rst ifid_instr", {16'd0, bus.ifid_instr}, {16'd0, NOP_W});
    chk("rst imem_addr",  bus.imem_addr,           32'd0);
`ifdef PC_SEQ_RESET_VECTOR_EN
    chk("rst fetch_busy", {31'd0, bus.fetch_busy}, 32'd1);
`else
    chk("rst fetch_busy", {31'd0, bus.fetch_busy}, 32'd0);
`endif

    @(negedge clk);
    rst_n = 1'b1;
    #1;

`ifdef PC_SEQ_RESET_VECTOR_EN
    // Vector load: two busy cycles, stray control inputs ignored
    bus.flush = 1'b1;
    bus.jump_taken = 1'b1;
    bus.jump_target = 32'h999;
    chk("vlo busy", {31'd0, bus.fetch_busy}, 32'd1);
    chk("vlo addr", bus.imem_addr, 32'd0);
    tick();
    chk("vhi busy", {31'd0, bus.fetch_busy}, 32'd1);
    chk("vhi addr", bus.imem_addr, 32'd1);
    chk("vhi valid", {31'd0, bus.ifid_valid}, 32'd0);
    tick();
    idle_inputs();
    chk("run busy", {31'd0, bus.fetch_busy}, 32'd0);
    chk("run addr", bus.imem_addr, 32'h10);
    chk("run valid", {31'd0, bus.ifid_valid}, 32'd0);
`else
    // Direct start at RESET_PC, then jump to 0x10 to reach the table start
    chk("start busy", {31'd0, bus.fetch_busy}, 32'd0);
    chk("start addr", bus.imem_addr, 32'd0);
    bus.jump_taken  = 1'b1;
    bus.jump_target = 32'h10;
    tick();
    idle_inputs();
    chk("start addr2",  bus.imem_addr, 32'h10);
    chk("start ipc",    bus.ifid_pc, 32'd0);
    chk("start valid",  {31'd0, bus.ifid_valid}, 32'd1);
    chk("start instr",  {16'd0, bus.ifid_instr}, 32'h0010);
`endif

    // Table-driven RUN vectors through the scoreboard queue
    for (int i = 0; i < 18; i++) begin
      bus.ret_valid   = tbl[i].rv;
      bus.jump_taken  = tbl[i].jt;
      bus.stall       = tbl[i].st;
      bus.flush       = tbl[i].fl;
      bus.ret_pc      = tbl[i].rpc;
      bus.jump_target = tbl[i].jtgt;
      sb_q.push_back(tbl[i]);
      tick();
      if (sb_q.size() == 0) begin
        chk($sformatf("row%0d queue", i), 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("row%0d addr", i),  bus.imem_addr, e.e_addr);
        chk($sformatf("row%0d ipc", i),   bus.ifid_pc, e.e_ipc);
        chk($sformatf("row%0d valid", i), {31'd0, bus.ifid_valid}, {31'd0, e.e_v});
        chk($sformatf("row%0d instr", i), {16'd0, bus.ifid_instr},
            {16'd0, (e.e_v ? mem_word(e.e_ipc) : NOP_W)});
        chk($sformatf("row%0d busy", i),  {31'd0, bus.fetch_busy}, 32'd0);
      end
    end
    idle_inputs();

    // Mid-run reset between edges: outputs clear without a clock edge
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst valid", {31'd0, bus.ifid_valid}, 32'd0);
    chk("mrst ipc",   bus.ifid_pc, 32'd0);
    chk("mrst addr",  bus.imem_addr, 32'd0);
`ifdef PC_SEQ_RESET_VECTOR_EN
    chk("mrst busy",  {31'd0, bus.fetch_busy}, 32'd1);
`else
    chk("mrst busy",  {31'd0, bus.fetch_busy}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
`ifdef PC_SEQ_RESET_VECTOR_EN
    tick();
    chk("reload hi addr", bus.imem_addr, 32'd1);
    tick();
    chk("reload run addr", bus.imem_addr, 32'h10);
    tick();
    chk("reload ipc",   bus.ifid_pc, 32'h10);
    chk("reload valid", {31'd0, bus.ifid_valid}, 32'd1);
`else
    tick();
    chk("restart ipc",   bus.ifid_pc, 32'd0);
    chk("restart valid", {31'd0, bus.ifid_valid}, 32'd1);
    chk("restart addr",  bus.imem_addr, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
